eros_obi_demux_ot: RTL and testbench

- Parametrised 1-to-N OBI demultiplexer; next generation of the single-master crossbar front end.
- Adds configurable address/data width and multiple outstanding transactions with in-order response routing.
- Stalls any slave switch that could reorder responses; optionally answers unmapped addresses from an internal error responder.
- Sits between one OBI master (core or DMA port) and XBAR_NSLAVE peripheral/memory slaves.

---
 rtl/eros_obi_demux_ot.sv | 153 +++++++++++++++
 tb/tb_eros_obi_demux_ot.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eros_obi_demux_ot.sv
// 1-to-N OBI demux with in-order outstanding tracking; optional error responder via EROS_DEMUX_ERR_RESP_EN.
// Latency: request/grant path 0 cycles; responses pass through combinationally from the selected slave.
// Backpressure: gnt follows the target slave; switching targets stalls until all outstanding responses return.

package cf_math_pkg;
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 1) ? $clog2(num_idx) : 1;
    endfunction
endpackage

package addr_map_rule_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } addr_map_rule_t;
endpackage

module eros_obi_demux_ot #(
    parameter int unsigned XBAR_NSLAVE     = 2,
    parameter int unsigned NUM_RULES       = XBAR_NSLAVE,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] ERR_RDATA       = 32'hBADCAB1E,
    localparam int unsigned IdxWidth       = cf_math_pkg::idx_width(XBAR_NSLAVE),
    localparam int unsigned CntWidth       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  addr_map_rule_pkg::addr_map_rule_t [NUM_RULES-1:0] addr_map_i,
    input  logic [IdxWidth-1:0]                           default_idx_i,
    input  logic                                          master_req_i,
    input  logic                                          master_we_i,
    input  logic [DATA_WIDTH/8-1:0]                       master_be_i,
    input  logic [ADDR_WIDTH-1:0]                         master_addr_i,
    input  logic [DATA_WIDTH-1:0]                         master_wdata_i,
    output logic                                          master_gnt_o,
    output logic                                          master_rvalid_o,
    output logic [DATA_WIDTH-1:0]                         master_rdata_o,
    output logic                                          master_err_o,
    output logic [XBAR_NSLAVE-1:0]                        slave_req_o,
    output logic [XBAR_NSLAVE-1:0]                        slave_we_o,
    output logic [XBAR_NSLAVE-1:0][DATA_WIDTH/8-1:0]      slave_be_o,
    output logic [XBAR_NSLAVE-1:0][ADDR_WIDTH-1:0]        slave_addr_o,
    output logic [XBAR_NSLAVE-1:0][DATA_WIDTH-1:0]        slave_wdata_o,
    input  logic [XBAR_NSLAVE-1:0]                        slave_gnt_i,
    input  logic [XBAR_NSLAVE-1:0]                        slave_rvalid_i,
    input  logic [XBAR_NSLAVE-1:0][DATA_WIDTH-1:0]        slave_rdata_i,
    output logic [CntWidth-1:0]                           outstanding_o,
    output logic                                          stray_rsp_o
);

`ifdef EROS_DEMUX_ERR_RESP_EN
    localparam int unsigned TgtWidth = cf_math_pkg::idx_width(XBAR_NSLAVE + 1);
    localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(XBAR_NSLAVE);
    localparam logic [DATA_WIDTH-1:0] ErrRdata = DATA_WIDTH'(ERR_RDATA);
    logic unused_default_idx;
    assign unused_default_idx = ^default_idx_i;
`else
    localparam int unsigned TgtWidth = IdxWidth;
`endif

    logic [CntWidth-1:0] cnt;
    logic [TgtWidth-1:0] sel_q;
    logic [TgtWidth-1:0] tgt;
    logic [IdxWidth-1:0] dec_idx;
    logic                hit;
    logic                fwd;
    logic                tgt_gnt;
    logic                sel_rvalid;
    logic                sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                other_rvalid;
    logic                rsp;

    // Walk rules from the top so the lowest-numbered match wins.
    always_comb begin
        hit     = 1'b0;
        dec_idx = '0;
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (64'(master_addr_i) >= addr_map_i[r].start_addr &&
                64'(master_addr_i) <  addr_map_i[r].end_addr &&
                addr_map_i[r].idx  <  32'(XBAR_NSLAVE)) begin
                hit     = 1'b1;
                dec_idx = addr_map_i[r].idx[IdxWidth-1:0];
            end
        end
    end

`ifdef EROS_DEMUX_ERR_RESP_EN
    assign tgt = hit ? TgtWidth'(dec_idx) : ErrTgt;
`else
    assign tgt = hit ? dec_idx : default_idx_i;
`endif

    assign fwd = master_req_i && (cnt == '0 || tgt == sel_q) &&
                 (cnt < CntWidth'(MAX_OUTSTANDING));

    always_comb begin
        slave_req_o  = '0;
        tgt_gnt      = 1'b0;
        sel_rvalid   = 1'b0;
        sel_err      = 1'b0;
        sel_rdata    = '0;
        other_rvalid = 1'b0;
        for (int s = 0; s < XBAR_NSLAVE; s++) begin
            if (tgt == TgtWidth'(s)) begin
                slave_req_o[s] = fwd;
                tgt_gnt        = slave_gnt_i[s];
            end
            if (sel_q == TgtWidth'(s)) begin
                sel_rvalid = slave_rvalid_i[s];
                sel_rdata  = slave_rdata_i[s];
            end else if (slave_rvalid_i[s]) begin
                other_rvalid = 1'b1;
            end
        end
`ifdef EROS_DEMUX_ERR_RESP_EN
        // The error slave always grants and answers one transaction per cycle.
        if (tgt == ErrTgt) tgt_gnt = 1'b1;
        if (sel_q == ErrTgt) begin
            sel_rvalid = 1'b1;
            sel_err    = 1'b1;
            sel_rdata  = ErrRdata;
        end
`endif
    end

    assign rsp             = (cnt != '0) && sel_rvalid;
    assign master_gnt_o    = fwd && tgt_gnt;
    assign master_rvalid_o = rsp;
    assign master_rdata_o  = rsp ? sel_rdata : '0;
    assign master_err_o    = rsp && sel_err;
    assign stray_rsp_o     = other_rvalid || (cnt == '0 && (|slave_rvalid_i));
    assign outstanding_o   = cnt;

    assign slave_we_o    = {XBAR_NSLAVE{master_we_i}};
    assign slave_be_o    = {XBAR_NSLAVE{master_be_i}};
    assign slave_addr_o  = {XBAR_NSLAVE{master_addr_i}};
    assign slave_wdata_o = {XBAR_NSLAVE{master_wdata_i}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            sel_q <= '0;
        end else begin
            if (master_gnt_o) sel_q <= tgt;
            cnt <= cnt + CntWidth'(master_gnt_o) - CntWidth'(rsp);
        end
    end

endmodule

// File: tb/tb_eros_obi_demux_ot.sv
// Directed bench for eros_obi_demux_ot with a response scoreboard; expected responses queued at grant.
module tb_eros_obi_demux_ot;

    logic        clk = 1'b0;
    logic        rst;
    addr_map_rule_pkg::addr_map_rule_t [1:0] addr_map;
    logic [0:0]  default_idx;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic [1:0]  s_req, s_we, s_gnt, s_rvalid;
    logic [1:0][3:0]  s_be;
    logic [1:0][31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  outstanding;
    logic        stray;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    eros_obi_demux_ot dut (
        .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map), .default_idx_i(default_idx),
        .master_req_i(m_req), .master_we_i(m_we), .master_be_i(m_be),
        .master_addr_i(m_addr), .master_wdata_i(m_wdata),
        .master_gnt_o(m_gnt), .master_rvalid_o(m_rvalid), .master_rdata_o(m_rdata),
        .master_err_o(m_err), .slave_req_o(s_req), .slave_we_o(s_we), .slave_be_o(s_be),
        .slave_addr_o(s_addr), .slave_wdata_o(s_wdata), .slave_gnt_i(s_gnt),
        .slave_rvalid_i(s_rvalid), .slave_rdata_i(s_rdata),
        .outstanding_o(outstanding), .stray_rsp_o(stray)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, expect a same-cycle grant, optionally queue its expected response.
    task automatic issue(input logic [31:0] addr, input bit push, input logic [32:0] exp_rsp);
        m_req  = 1'b1;
        m_addr = addr;
        @(negedge clk);
        chk("issue_gnt", 64'(m_gnt), 64'(1));
        if (push && m_gnt) sb.push_back(exp_rsp);
        tick();
        m_req = 1'b0;
    endtask

    task automatic respond(input int s, input logic [31:0] data);
        s_rvalid[s] = 1'b1;
        s_rdata[s]  = data;
        tick();
        s_rvalid = '0;
        s_rdata  = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_rvalid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    chk("rsp_rdata", 64'(m_rdata), 64'(e[31:0]));
                    chk("rsp_err", 64'(m_err), 64'(e[32]));
                end
            end else begin
                chk("rdata_idle", 64'(m_rdata), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_map[0] = '{idx: 32'd0, start_addr: 64'h0000, end_addr: 64'h1000};
        addr_map[1] = '{idx: 32'd1, start_addr: 64'h1000, end_addr: 64'h2000};
        default_idx = 1'b1;
        rst = 1'b1;
        m_req = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
        s_gnt = '0; s_rvalid = '0; s_rdata = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_gnt", 64'(m_gnt), 64'(0));
        chk("rst_rvalid", 64'(m_rvalid), 64'(0));
        chk("rst_err", 64'(m_err), 64'(0));
        chk("rst_sreq", 64'(s_req), 64'(0));
        chk("rst_cnt", 64'(outstanding), 64'(0));
        chk("rst_stray", 64'(stray), 64'(0));
        tick();
        rst = 1'b0;
        s_gnt = 2'b11;
        m_be = 4'hA;

        // Single read to slave0, response two cycles after grant.
        m_req = 1'b1; m_addr = 32'h10;
        @(negedge clk);
        chk("t1_sreq", 64'(s_req), 64'(2'b01));
        chk("t1_gnt", 64'(m_gnt), 64'(1));
        chk("t1_bcast_addr", 64'(s_addr[1]), 64'(32'h10));
        chk("t1_bcast_be", 64'(s_be[1]), 64'(4'hA));
        sb.push_back({1'b0, 32'hCAFE0001});
        tick(); m_req = 1'b0;
        @(negedge clk);
        chk("t1_cnt1", 64'(outstanding), 64'(1));
        tick();
        respond(0, 32'hCAFE0001);
        @(negedge clk);
        chk("t1_cnt0", 64'(outstanding), 64'(0));

        // Fill to MAX_OUTSTANDING on slave1, then the fifth waits for a response.
        tick();
        for (int k = 0; k < 4; k++) issue(32'h1000, 1'b1, {1'b0, 32'hB000_0000 + 32'(k)});
        m_req = 1'b1; m_addr = 32'h1000;
        @(negedge clk);
        chk("t2_full_gnt", 64'(m_gnt), 64'(0));
        chk("t2_full_sreq", 64'(s_req), 64'(0));
        chk("t2_full_cnt", 64'(outstanding), 64'(4));
        tick();
        s_rvalid[1] = 1'b1; s_rdata[1] = 32'hB000_0000;
        @(negedge clk);
        chk("t2_full_rsp_gnt", 64'(m_gnt), 64'(0));
        tick();
        s_rvalid = '0; s_rdata = '0;
        @(negedge clk);
        chk("t2_fifth_gnt", 64'(m_gnt), 64'(1));
        if (m_gnt) sb.push_back({1'b0, 32'hB000_0004});
        tick(); m_req = 1'b0;
        for (int k = 1; k < 5; k++) respond(1, 32'hB000_0000 + 32'(k));
        @(negedge clk);
        chk("t2_cnt0", 64'(outstanding), 64'(0));

        // Target switch stalls until the slave0 response drains.
        tick();
        issue(32'h0, 1'b1, {1'b0, 32'h5000_0000});
        m_req = 1'b1; m_addr = 32'h1004;
        @(negedge clk);
        chk("t3_stall_sreq", 64'(s_req), 64'(0));
        chk("t3_stall_gnt", 64'(m_gnt), 64'(0));
        tick();
        s_rvalid[0] = 1'b1; s_rdata[0] = 32'h5000_0000;
        @(negedge clk);
        chk("t3_rsp_sreq", 64'(s_req), 64'(0));
        tick();
        s_rvalid = '0; s_rdata = '0;
        @(negedge clk);
        chk("t3_switch_sreq", 64'(s_req), 64'(2'b10));
        chk("t3_switch_gnt", 64'(m_gnt), 64'(1));
        if (m_gnt) sb.push_back({1'b0, 32'h6000_0000});
        tick(); m_req = 1'b0;
        respond(1, 32'h6000_0000);

        // Grant and response in the same cycle at cnt=2.
        issue(32'h20, 1'b1, {1'b0, 32'h7000_0000});
        issue(32'h24, 1'b1, {1'b0, 32'h7000_0001});
        m_req = 1'b1; m_addr = 32'h28;
        s_rvalid[0] = 1'b1; s_rdata[0] = 32'h7000_0000;
        @(negedge clk);
        chk("t4_gnt", 64'(m_gnt), 64'(1));
        if (m_gnt) sb.push_back({1'b0, 32'h7000_0002});
        tick();
        m_req = 1'b0; s_rvalid = '0; s_rdata = '0;
        @(negedge clk);
        chk("t4_cnt2", 64'(outstanding), 64'(2));
        tick();
        respond(0, 32'h7000_0001);
        respond(0, 32'h7000_0002);

        // Decode miss.
`ifdef EROS_DEMUX_ERR_RESP_EN
        m_req = 1'b1; m_addr = 32'h8000;
        @(negedge clk);
        chk("t5_err_gnt", 64'(m_gnt), 64'(1));
        chk("t5_err_sreq", 64'(s_req), 64'(0));
        if (m_gnt) sb.push_back({1'b1, 32'hBADCAB1E});
        tick(); m_req = 1'b0;
        @(negedge clk);
        chk("t5_err_rvalid", 64'(m_rvalid), 64'(1));
        tick();
`else
        m_req = 1'b1; m_addr = 32'h8000;
        @(negedge clk);
        chk("t5_dflt_sreq", 64'(s_req), 64'(2'b10));
        chk("t5_dflt_gnt", 64'(m_gnt), 64'(1));
        if (m_gnt) sb.push_back({1'b0, 32'h8000_0001});
        tick(); m_req = 1'b0;
        respond(1, 32'h8000_0001);
`endif
        @(negedge clk);
        chk("t5_cnt0", 64'(outstanding), 64'(0));

        // Stray responses: at cnt==0, and from a non-selected slave.
        tick();
        s_rvalid[0] = 1'b1; s_rdata[0] = 32'hDEAD0000;
        @(negedge clk);
        chk("t6_stray0", 64'(stray), 64'(1));
        chk("t6_stray0_rv", 64'(m_rvalid), 64'(0));
        tick();
        s_rvalid = '0; s_rdata = '0;
        @(negedge clk);
        chk("t6_stray_clr", 64'(stray), 64'(0));
        tick();
        issue(32'h30, 1'b1, {1'b0, 32'h9000_0000});
        s_rvalid[1] = 1'b1; s_rdata[1] = 32'hDEAD0001;
        @(negedge clk);
        chk("t6_stray1", 64'(stray), 64'(1));
        chk("t6_stray1_cnt", 64'(outstanding), 64'(1));
        tick();
        s_rvalid = '0; s_rdata = '0;
        respond(0, 32'h9000_0000);

        // Reset with three outstanding drops tracking; late response is stray.
        for (int k = 0; k < 3; k++) issue(32'h1100, 1'b0, 33'h0);
        @(negedge clk);
        chk("t7_cnt3", 64'(outstanding), 64'(3));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_rst_cnt", 64'(outstanding), 64'(0));
        tick();
        s_rvalid[1] = 1'b1; s_rdata[1] = 32'hDEAD0002;
        @(negedge clk);
        chk("t7_late_stray", 64'(stray), 64'(1));
        chk("t7_late_rv", 64'(m_rvalid), 64'(0));
        tick();
        s_rvalid = '0; s_rdata = '0;
        tick();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
